// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: ALUControl codes, FSM states and op classification.
// The ALU_MC_DIV_EN macro decides whether DIV is an implemented (iterative) op.
package alu_mc_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SRA = 4'b1101;
    localparam logic [3:0] OP_SLL = 4'b1110;
    localparam logic [3:0] OP_SRL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ops that run through the shared shift-add / restoring-divide datapath.
    function automatic logic op_is_iter(input logic [3:0] code);
`ifdef ALU_MC_DIV_EN
        return (code == OP_MUL) || (code == OP_DIV);
`else
        return (code == OP_MUL);
`endif
    endfunction

    function automatic logic op_is_known(input logic [3:0] code);
        logic known;
        case (code)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
            OP_NOR, OP_SRA, OP_SLL, OP_SRL, OP_MUL: known = 1'b1;
            default:                                  known = op_is_iter(code);
        endcase
        return known;
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared iterative datapath: one-bit-per-cycle unsigned shift-add multiply and, when
// ALU_MC_DIV_EN is defined, unsigned restoring divide. {hi,lo} holds product or {rem,quot}.
module alu_mc_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef ALU_MC_DIV_EN
    input  logic             mode_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH:0]   mul_sum;

    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_p0} : {(WIDTH+1){1'b0}});
    assign done    = busy && (cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_MC_DIV_EN
    logic             mode_p0;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // Remainder stays below the divisor, so the top bit of div_diff is a pure borrow flag.
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_p0};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    // ---- iteration stage: load on start, one bit per cycle while busy ----
    always_ff @(posedge clk) begin
        if (start) begin
            hi   <= '0;
            lo   <= a;
            b_p0 <= b;
`ifdef ALU_MC_DIV_EN
            mode_p0 <= mode_div;
`endif
        end else if (busy) begin
`ifdef ALU_MC_DIV_EN
            if (mode_p0) begin
                if (!div_diff[WIDTH]) begin
                    hi <= div_diff[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= div_shift[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi <= mul_sum[WIDTH:1];
                lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
`else
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
`endif
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with valid/ready handshake and registered result/flags.
// Define ALU_MC_DIV_EN to compile in the iterative unsigned divider (op 1001).
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               ovf,
    output logic               bad_op
);

    state_t state_q;
    state_t state_nxt;

    logic accept;
    logic iter_start;
    logic iter_done;
    logic load_out;
    logic pop;

    logic [3:0]         op_p0;
    logic [WIDTH-1:0]   a_p0;
    logic [WIDTH-1:0]   b_p0;
    logic [SHAMT_W-1:0] shamt_p0;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;

    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] hi_nxt;
    logic             ovf_nxt;
    logic             bad_nxt;

    // Two's-complement overflow of a + b_eff, given the sign bits of both addends and the sum.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    assign accept     = in_valid && in_ready;
    assign iter_start = accept && op_is_iter(op);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = op_is_iter(op) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // DONE is entered one edge before the result registers load, so out_valid marks "loaded".
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        load_out = (state_q == ST_DONE) && !out_valid;
        pop      = (state_q == ST_DONE) && out_valid && out_ready;
    end

    // ---- capture stage: operands latched on accept ----
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0    <= op;
            a_p0     <= rs;
            b_p0     <= rt;
            shamt_p0 <= shamt;
        end
    end

    alu_mc_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (iter_start),
`ifdef ALU_MC_DIV_EN
        .mode_div (op == OP_DIV),
`endif
        .a        (rs),
        .b        (rt),
        .done     (iter_done),
        .lo       (iter_lo),
        .hi       (iter_hi)
    );

    assign a_s = a_p0;
    assign b_s = b_p0;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_p0)
            OP_AND: alu_res = a_p0 & b_p0;
            OP_OR:  alu_res = a_p0 | b_p0;
            OP_NOR: alu_res = ~(a_p0 | b_p0);
            OP_ADD: begin
                alu_res = a_p0 + b_p0;
                alu_ovf = add_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], alu_res[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = a_p0 - b_p0;
                alu_ovf = add_ovf(a_p0[WIDTH-1], ~b_p0[WIDTH-1], alu_res[WIDTH-1]);
            end
            OP_SLT: alu_res = (a_s < b_s) ? WIDTH'(1) : '0;
            OP_SRA: alu_res = b_s >>> shamt_p0;
            OP_SLL: alu_res = b_p0 << shamt_p0;
            OP_SRL: alu_res = b_p0 >> shamt_p0;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        res_nxt = alu_res;
        hi_nxt  = '0;
        ovf_nxt = alu_ovf;
        bad_nxt = 1'b0;
        if (op_is_iter(op_p0)) begin
            res_nxt = iter_lo;
            hi_nxt  = iter_hi;
            ovf_nxt = 1'b0;
        end else if (!op_is_known(op_p0)) begin
            res_nxt = '0;
            ovf_nxt = 1'b0;
            bad_nxt = 1'b1;
        end
    end

    // ---- output stage: result and flags held from load until the next load or reset ----
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            bad_op    <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            result    <= res_nxt;
            result_hi <= hi_nxt;
            zero      <= (res_nxt == '0);
            ovf       <= ovf_nxt;
            bad_op    <= bad_nxt;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus randomized ops against a
// plain-arithmetic reference model; honours ALU_MC_DIV_EN for the DIV expectations.
module tb_alu_mc;

    localparam int W = 32;
    localparam longint MAXS = 2147483647;
    localparam longint MINS = -MAXS - 1;
`ifdef ALU_MC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         ov;
        logic         bad;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic [4:0]   shamt = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         ovf;
    logic         bad_op;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .ovf       (ovf),
        .bad_op    (bad_op)
    );

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [4:0] s);
        exp_t e;
        longint sa, sb, t;
        logic [63:0] p;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0010: begin t = sa + sb; e.res = W'(t); e.ov = (t > MAXS) || (t < MINS); end
            4'b0110: begin t = sa - sb; e.res = W'(t); e.ov = (t > MAXS) || (t < MINS); end
            4'b0111: e.res = (sa < sb) ? W'(1) : W'(0);
            4'b1101: begin t = sb >>> s; e.res = W'(t); end
            4'b1110: e.res = b << s;
            4'b1111: e.res = b >> s;
            4'b1000: begin p = 64'(a) * 64'(b); e.res = p[31:0]; e.hi = p[63:32]; end
            4'b1001: begin
                if (DIV_EN) begin
                    e.res = (b == 0) ? '1 : a / b;
                    e.hi  = (b == 0) ? a : a % b;
                end else begin
                    e.bad = 1'b1;
                end
            end
            default: e.bad = 1'b1;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    function automatic int exp_lat(input logic [3:0] o);
        return (o == 4'b1000 || (DIV_EN && o == 4'b1001)) ? W + 1 : 1;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Offers one op, then counts edges until out_valid; rdy_seen counts cycles in_ready was high meanwhile.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] s, output int lat, output int rdy_seen);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        op = o; rs = a; rt = b; shamt = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'($urandom); rs = $urandom; rt = $urandom; shamt = 5'($urandom);
        lat = 0;
        rdy_seen = 0;
        while (out_valid !== 1'b1 && lat < W + 8) begin
            if (in_ready !== 1'b0) rdy_seen++;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic pop(output logic rdy, output logic vld);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rdy = in_ready;
        vld = out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1)   $display("FAIL reset_in_ready got %b want 1", in_ready);   else passed++;
        checks++; if (out_valid !== 1'b0)  $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (result !== '0)       $display("FAIL reset_result got %h want 0", result);       else passed++;
        checks++; if (result_hi !== '0)    $display("FAIL reset_result_hi got %h want 0", result_hi); else passed++;
        checks++; if ({zero, ovf, bad_op} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {zero, ovf, bad_op}); else passed++;
    endtask

    task automatic test_directed();
        int lat, rs_cnt;
        logic rdy, vld;
        issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, lat, rs_cnt);
        checks++; if (lat !== 1) $display("FAIL add_latency got %0d want 1", lat); else passed++;
        checks++; if ({result, ovf, zero} !== {32'h8000_0000, 1'b1, 1'b0})
            $display("FAIL add_ovf got %h ovf=%b zero=%b want 80000000 ovf=1 zero=0", result, ovf, zero); else passed++;
        pop(rdy, vld);
        checks++; if ({rdy, vld} !== 2'b10) $display("FAIL add_pop got rdy=%b vld=%b want 1 0", rdy, vld); else passed++;

        issue(4'b0110, 32'd5, 32'd5, 5'd0, lat, rs_cnt);
        checks++; if ({result, zero, ovf} !== {32'h0, 1'b1, 1'b0})
            $display("FAIL sub_zero got %h zero=%b ovf=%b want 0 1 0", result, zero, ovf); else passed++;
        pop(rdy, vld);

        issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, lat, rs_cnt);
        checks++; if (result !== 32'h1) $display("FAIL slt_signed got %h want 1", result); else passed++;
        pop(rdy, vld);

        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, lat, rs_cnt);
        checks++; if (lat !== 33) $display("FAIL mul_latency got %0d want 33", lat); else passed++;
        checks++; if (rs_cnt !== 0) $display("FAIL mul_in_ready got %0d high cycles want 0", rs_cnt); else passed++;
        checks++; if ({result_hi, result} !== {32'hFFFF_FFFE, 32'h0000_0001})
            $display("FAIL mul_product got %h_%h want fffffffe_00000001", result_hi, result); else passed++;
        pop(rdy, vld);

        issue(4'b1001, 32'h100, 32'h7, 5'd0, lat, rs_cnt);
        if (DIV_EN) begin
            checks++; if ({lat, result, result_hi, bad_op} !== {33, 32'h24, 32'h4, 1'b0})
                $display("FAIL div_basic got lat=%0d q=%h r=%h bad=%b want 33 24 4 0", lat, result, result_hi, bad_op); else passed++;
        end else begin
            checks++; if ({lat, result, result_hi, bad_op, zero} !== {1, 32'h0, 32'h0, 1'b1, 1'b1})
                $display("FAIL div_absent got lat=%0d q=%h r=%h bad=%b z=%b want 1 0 0 1 1", lat, result, result_hi, bad_op, zero); else passed++;
        end
        pop(rdy, vld);

        issue(4'b1001, 32'h100, 32'h0, 5'd0, lat, rs_cnt);
        if (DIV_EN) begin
            checks++; if ({lat, result, result_hi, bad_op} !== {33, 32'hFFFF_FFFF, 32'h100, 1'b0})
                $display("FAIL div_by_zero got lat=%0d q=%h r=%h bad=%b want 33 ffffffff 100 0", lat, result, result_hi, bad_op); else passed++;
        end else begin
            checks++; if ({result, bad_op} !== {32'h0, 1'b1})
                $display("FAIL div0_absent got q=%h bad=%b want 0 1", result, bad_op); else passed++;
        end
        pop(rdy, vld);
    endtask

    task automatic test_hold();
        int lat, rs_cnt;
        logic rdy, vld;
        issue(4'b1101, 32'h0, 32'h8000_0000, 5'd4, lat, rs_cnt);
        op = 4'b0010; rs = 32'd2; rt = 32'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if ({result, out_valid, in_ready} !== {32'hF800_0000, 1'b1, 1'b0})
                $display("FAIL hold_stable cyc %0d got %h vld=%b rdy=%b want f8000000 1 0", i, result, out_valid, in_ready); else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL hold_pop got rdy=%b vld=%b want 1 0", in_ready, out_valid); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b00)
            $display("FAIL pop_plus1_accept got rdy=%b vld=%b want 0 0", in_ready, out_valid); else passed++;
        @(posedge clk); #1;
        checks++; if ({out_valid, result} !== {1'b1, 32'd5})
            $display("FAIL after_hold_add got vld=%b %h want 1 5", out_valid, result); else passed++;
        pop(rdy, vld);
    endtask

    task automatic test_reset_abort();
        int lat, rs_cnt, stale, n;
        logic rdy, vld;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        op = 4'b1000; rs = 32'hFFFF_FFFF; rt = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL mul_abort_hs got vld=%b rdy=%b want 0 1", out_valid, in_ready); else passed++;
        checks++; if ({result, result_hi, zero, ovf, bad_op} !== '0)
            $display("FAIL mul_abort_out got %h %h z=%b o=%b b=%b want zeros", result, result_hi, zero, ovf, bad_op); else passed++;
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        checks++; if (stale !== 0) $display("FAIL mul_abort_stale got %0d valid cycles want 0", stale); else passed++;

        issue(4'b0010, 32'd2, 32'd3, 5'd0, lat, rs_cnt);
        checks++; if ({lat, result} !== {1, 32'd5})
            $display("FAIL post_reset_add got lat=%0d %h want 1 5", lat, result); else passed++;
        pop(rdy, vld);

        issue(4'b0111, 32'd1, 32'd2, 5'd0, lat, rs_cnt);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'h0})
            $display("FAIL done_abort got vld=%b rdy=%b %h want 0 1 0", out_valid, in_ready, result); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        int lat, rs_cnt;
        logic [3:0] o;
        logic [W-1:0] a, b;
        logic [4:0] s;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            o = ops[$urandom_range(0, 8)]; a = pick_operand(); b = pick_operand(); s = 5'($urandom);
            e = model(o, a, b, s);
            issue(o, a, b, s, lat, rs_cnt);
            checks++; if ({lat, result, zero, ovf} !== {1, e.res, e.z, e.ov})
                $display("FAIL b2b op=%b got lat=%0d %h z=%b o=%b want 1 %h %b %b", o, lat, result, zero, ovf, e.res, e.z, e.ov); else passed++;
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready} !== 2'b01)
                $display("FAIL b2b_pop op=%b got vld=%b rdy=%b want 0 1", o, out_valid, in_ready); else passed++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat, rs_cnt, hold, unstable;
        logic rdy, vld;
        logic [3:0] o;
        logic [W-1:0] a, b;
        logic [4:0] s;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            o = (i % 8 == 0) ? 4'b1000 : (i % 8 == 4) ? 4'b1001 : 4'($urandom_range(0, 15));
            a = pick_operand(); b = pick_operand(); s = 5'($urandom);
            if (i % 16 == 12) b = '0;
            e = model(o, a, b, s);
            issue(o, a, b, s, lat, rs_cnt);
            checks++; if (lat !== exp_lat(o) || rs_cnt !== 0)
                $display("FAIL rnd_timing op=%b got lat=%0d rdy_hi=%0d want lat=%0d rdy_hi=0", o, lat, rs_cnt, exp_lat(o)); else passed++;
            checks++; if ({result, result_hi} !== {e.res, e.hi})
                $display("FAIL rnd_data op=%b a=%h b=%h s=%0d got %h_%h want %h_%h", o, a, b, s, result_hi, result, e.hi, e.res); else passed++;
            checks++; if ({zero, ovf, bad_op} !== {e.z, e.ov, e.bad})
                $display("FAIL rnd_flags op=%b a=%h b=%h got z%b o%b b%b want z%b o%b b%b", o, a, b, zero, ovf, bad_op, e.z, e.ov, e.bad); else passed++;
            hold = $urandom_range(0, 3);
            unstable = 0;
            repeat (hold) begin
                @(posedge clk); #1;
                if ({out_valid, result, result_hi, zero, ovf, bad_op} !== {1'b1, e.res, e.hi, e.z, e.ov, e.bad}) unstable++;
            end
            checks++; if (unstable !== 0) $display("FAIL rnd_hold op=%b got %0d unstable cycles want 0", o, unstable); else passed++;
            pop(rdy, vld);
            checks++; if ({rdy, vld} !== 2'b10) $display("FAIL rnd_pop op=%b got rdy=%b vld=%b want 1 0", o, rdy, vld); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout after %0d/%0d checks", passed, checks);
        $fatal(1, "bench time limit reached");
    end

endmodule
